// File: rtl/note_dropper_lane.sv
// note_dropper_lane: one falling note with start delay, clamped fall
// and PERFECT/GOOD/MISS grading of an edge-qualified key press.
module note_dropper_lane #(
   parameter logic [7:0] LANE_KEY       = 8'h07,
   parameter logic [7:0] START_KEY      = 8'h2C,
   parameter logic [7:0] RESTART_KEY    = 8'h01,
   parameter int         CNT_W          = 12,
   parameter int         DELAY          = 2180,
   parameter int         X_START        = 160,
   parameter int         Y_START        = 100,
   parameter int         SIZE           = 40,
   parameter int         Y_MAX          = 400,
   parameter int         HIT_LO         = 340,
   parameter int         PERFECT_CENTER = 370,
   parameter int         PERFECT_TOL    = 8,
   parameter int         SPEED          = 1
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic [7:0] keycode,
   input  logic [7:0] keycode_second,
   output logic [9:0] dropX,
   output logic [9:0] dropY,
   output logic       visible,
   output logic       score,
   output logic       hit_perfect,
   output logic       hit_good,
   output logic       miss
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      FALL = 3'd2,
      HIT  = 3'd3,
      MISS = 3'd4
   } state_t;

   localparam logic [9:0]  Y_REST = 10'(Y_START);
   localparam logic [9:0]  Y_LAND = 10'(Y_MAX - SIZE);
   localparam logic [9:0]  STEP   = 10'(SPEED);
   localparam logic [10:0] SIZE_W = 11'(SIZE);
   localparam logic [10:0] STEP_W = 11'(SPEED);
   localparam logic [10:0] MAX_W  = 11'(Y_MAX);
   localparam logic [10:0] HIT_W  = 11'(HIT_LO);
   localparam logic [10:0] PERF_LO =
      (PERFECT_CENTER > PERFECT_TOL) ?
      11'(PERFECT_CENTER - PERFECT_TOL) : 11'd0;
   localparam logic [10:0] PERF_HI =
      11'(PERFECT_CENTER + PERFECT_TOL);
   // DELAY of 0 leaves WAIT on its first frame, same as DELAY of 1
   localparam logic [CNT_W-1:0] CNT_LAST =
      (DELAY == 0) ? '0 : CNT_W'(DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_d;
   logic [9:0]       y, y_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             key_prev;
   logic             perf_d, good_d, miss_d;
   logic             pressed, new_press;
   logic [10:0]      bottom, landing;

   assign pressed   = (keycode == LANE_KEY) |
                      (keycode_second == LANE_KEY);
   assign new_press = pressed & ~key_prev;
   assign bottom    = {1'b0, y} + SIZE_W;
   assign landing   = bottom + STEP_W;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         y           <= Y_REST;
         cnt         <= '0;
         key_prev    <= 1'b0;
         hit_perfect <= 1'b0;
         hit_good    <= 1'b0;
         miss        <= 1'b0;
      end else begin
         state       <= state_d;
         y           <= y_d;
         cnt         <= cnt_d;
         key_prev    <= pressed;
         hit_perfect <= perf_d;
         hit_good    <= good_d;
         miss        <= miss_d;
      end
   end

   always_comb begin
      state_d = state;
      y_d     = y;
      cnt_d   = cnt;
      perf_d  = 1'b0;
      good_d  = 1'b0;
      miss_d  = 1'b0;
      unique case (state)
         IDLE: begin
            y_d   = Y_REST;
            cnt_d = '0;
            if (keycode == START_KEY)
               state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt + CNT_ONE;
            if (cnt == CNT_LAST)
               state_d = FALL;
         end
         FALL: begin
            if (bottom >= MAX_W) begin
               state_d = MISS;
               miss_d  = 1'b1;
               y_d     = Y_LAND;
            end else if (new_press && bottom >= HIT_W) begin
               state_d = HIT;
               if (bottom >= PERF_LO && bottom <= PERF_HI)
                  perf_d = 1'b1;
               else
                  good_d = 1'b1;
            end else if (landing > MAX_W) begin
               y_d = Y_LAND;
            end else begin
               y_d = y + STEP;
            end
         end
         HIT, MISS: begin
            if (keycode == RESTART_KEY) begin
               state_d = IDLE;
               y_d     = Y_REST;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            y_d     = Y_REST;
            cnt_d   = '0;
         end
      endcase
   end

   assign dropX   = 10'(X_START);
   assign dropY   = y;
   assign visible = (state == WAIT) | (state == FALL);
   assign score   = (state == HIT);

endmodule

// File: tb/tb_note_dropper_lane.sv
// tb_note_dropper_lane: two lanes (slow DELAY=4, fast DELAY=0/SPEED=7)
// checked every frame against an arithmetic reference model.
module tb_note_dropper_lane;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_FALL = 2;
   localparam int M_HIT  = 3;
   localparam int M_MISS = 4;

   logic       frame_clk;
   logic       Reset_n;
   logic [7:0] keycode;
   logic [7:0] keycode_second;
   logic [9:0] dx [2];
   logic [9:0] dy [2];
   logic       vis [2];
   logic       sc [2];
   logic       hp [2];
   logic       hg [2];
   logic       ms [2];

   int npass;
   int ntot;

   int md [2];
   int wc [2];
   int nf [2];
   int ym [2];
   bit ep [2];
   bit eg [2];
   bit em [2];
   bit kprev;

   note_dropper_lane #(.DELAY(4), .SPEED(1)) u_slow (
      .frame_clk(frame_clk), .Reset_n(Reset_n),
      .keycode(keycode), .keycode_second(keycode_second),
      .dropX(dx[0]), .dropY(dy[0]), .visible(vis[0]),
      .score(sc[0]), .hit_perfect(hp[0]),
      .hit_good(hg[0]), .miss(ms[0])
   );

   note_dropper_lane #(.DELAY(0), .SPEED(7)) u_fast (
      .frame_clk(frame_clk), .Reset_n(Reset_n),
      .keycode(keycode), .keycode_second(keycode_second),
      .dropX(dx[1]), .dropY(dy[1]), .visible(vis[1]),
      .score(sc[1]), .hit_perfect(hp[1]),
      .hit_good(hg[1]), .miss(ms[1])
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   function automatic int spd(input int i);
      return (i == 0) ? 1 : 7;
   endfunction

   function automatic int dly(input int i);
      return (i == 0) ? 4 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      kprev = 0;
      for (int i = 0; i < 2; i++) begin
         md[i] = M_IDLE; wc[i] = 0; nf[i] = 0; ym[i] = 100;
         ep[i] = 0; eg[i] = 0; em[i] = 0;
      end
   endtask

   // One frame of the game rules for both lanes, keyed on the inputs
   // that were present at the clock edge.
   task automatic model_edge(input logic [7:0] k1, input logic [7:0] k2);
      bit pr, np;
      int bot, dev, fy;
      pr = (k1 == 8'h07) || (k2 == 8'h07);
      np = pr && !kprev;
      kprev = pr;
      for (int i = 0; i < 2; i++) begin
         ep[i] = 0; eg[i] = 0; em[i] = 0;
         case (md[i])
            M_IDLE: if (k1 == 8'h2C) begin md[i] = M_WAIT; wc[i] = 0; end
            M_WAIT: begin
               wc[i]++;
               if (wc[i] >= ((dly(i) > 0) ? dly(i) : 1)) begin
                  md[i] = M_FALL; nf[i] = 0;
               end
            end
            M_FALL: begin
               bot = ym[i] + 40;
               dev = (bot > 370) ? bot - 370 : 370 - bot;
               if (bot >= 400) begin
                  md[i] = M_MISS; em[i] = 1;
               end else if (np && bot >= 340) begin
                  md[i] = M_HIT;
                  if (dev <= 8) ep[i] = 1; else eg[i] = 1;
               end else nf[i]++;
            end
            default: if (k1 == 8'h01) md[i] = M_IDLE;
         endcase
         if (md[i] == M_IDLE || md[i] == M_WAIT) ym[i] = 100;
         else if (md[i] == M_FALL) begin
            fy = 100 + nf[i] * spd(i);
            ym[i] = (fy > 360) ? 360 : fy;
         end else if (md[i] == M_MISS) ym[i] = 360;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("lane%0d_dropX", i), dx[i], 160);
         chk($sformatf("lane%0d_dropY", i), dy[i], ym[i]);
         chk($sformatf("lane%0d_visible", i), vis[i],
             (md[i] == M_WAIT || md[i] == M_FALL) ? 1 : 0);
         chk($sformatf("lane%0d_score", i), sc[i],
             (md[i] == M_HIT) ? 1 : 0);
         chk($sformatf("lane%0d_perfect", i), hp[i], ep[i]);
         chk($sformatf("lane%0d_good", i), hg[i], eg[i]);
         chk($sformatf("lane%0d_miss", i), ms[i], em[i]);
      end
   endtask

   task automatic frame(input logic [7:0] k1, input logic [7:0] k2);
      keycode = k1;
      keycode_second = k2;
      @(posedge frame_clk);
      model_edge(k1, k2);
      #1 check_all();
   endtask

   task automatic run_until_y(input int lane, input int yt,
                              input logic [7:0] k1, input logic [7:0] k2,
                              input int budget);
      int n;
      n = 0;
      while (!(md[lane] == M_FALL && ym[lane] == yt)) begin
         if (n >= budget) begin
            ntot++;
            $error("FAIL timeout lane%0d waiting dropY=%0d", lane, yt);
            break;
         end
         frame(k1, k2);
         n++;
      end
   endtask

   initial begin
      npass = 0;
      ntot = 0;
      Reset_n = 1'b0;
      keycode = 8'h00;
      keycode_second = 8'h00;
      model_reset();
      @(posedge frame_clk);
      #1 check_all();
      @(posedge frame_clk);
      #1 check_all();
      Reset_n = 1'b1;

      // start both lanes; fast lane clamps and takes a press at bottom=400
      frame(8'h2C, 8'h00);
      chk("start_visible", vis[0], 1);
      run_until_y(1, 360, 8'h00, 8'h00, 100);
      frame(8'h07, 8'h00);
      chk("clamp_miss", ms[1], 1);
      chk("clamp_no_perfect", hp[1], 0);
      chk("clamp_no_good", hg[1], 0);
      chk("clamp_dropY", dy[1], 360);
      frame(8'h00, 8'h00);

      // slow lane falls untouched to the miss line
      run_until_y(0, 360, 8'h00, 8'h00, 400);
      frame(8'h00, 8'h00);
      chk("slow_miss", ms[0], 1);
      chk("slow_miss_score", sc[0], 0);
      chk("slow_miss_dropY", dy[0], 360);
      frame(8'h00, 8'h00);
      chk("slow_miss_one_frame", ms[0], 0);
      frame(8'h01, 8'h00);
      chk("restart_dropY", dy[0], 100);

      // perfect on the secondary keycode at bottom=370
      frame(8'h2C, 8'h00);
      run_until_y(0, 330, 8'h00, 8'h00, 400);
      frame(8'h00, 8'h07);
      chk("perfect_pulse", hp[0], 1);
      chk("perfect_score", sc[0], 1);
      chk("perfect_dropY", dy[0], 330);
      frame(8'h00, 8'h00);
      chk("perfect_one_frame", hp[0], 0);
      chk("perfect_frozen", dy[0], 330);
      frame(8'h01, 8'h00);

      // good at bottom=345
      frame(8'h2C, 8'h00);
      run_until_y(0, 305, 8'h00, 8'h00, 400);
      frame(8'h07, 8'h00);
      chk("good_pulse", hg[0], 1);
      chk("good_not_perfect", hp[0], 0);
      frame(8'h00, 8'h00);
      frame(8'h01, 8'h00);

      // key held from bottom=300 never scores
      frame(8'h2C, 8'h00);
      run_until_y(0, 260, 8'h00, 8'h00, 400);
      for (int n = 0; n < 200 && md[0] == M_FALL; n++)
         frame(8'h00, 8'h07);
      chk("held_miss", ms[0], 1);
      chk("held_score", sc[0], 0);
      frame(8'h00, 8'h00);
      frame(8'h01, 8'h00);

      // randomized key traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [7:0] k1, k2;
         r = $urandom_range(0, 99);
         if (r < 4) k1 = 8'h2C;
         else if (r < 8) k1 = 8'h01;
         else if (r < 30) k1 = 8'h07;
         else if (r < 35) k1 = 8'($urandom);
         else k1 = 8'h00;
         k2 = ($urandom_range(0, 9) < 2) ? 8'h07 : 8'h00;
         frame(k1, k2);
      end

      // back to IDLE, then async reset mid-fall at dropY=250
      for (int n = 0; n < 400 && md[0] != M_IDLE; n++)
         frame(8'h01, 8'h00);
      frame(8'h2C, 8'h00);
      run_until_y(0, 250, 8'h00, 8'h00, 400);
      #2 Reset_n = 1'b0;
      model_reset();
      #1 check_all();
      chk("async_dropY", dy[0], 100);
      chk("async_visible", vis[0], 0);
      chk("async_score", sc[0], 0);
      @(posedge frame_clk);
      #1 check_all();
      Reset_n = 1'b1;
      for (int n = 0; n < 6; n++)
         frame(8'h01, 8'h00);
      chk("restart_key_no_start", vis[0], 0);
      chk("restart_key_dropY", dy[0], 100);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/note_dropper_lane.md
Name: note_dropper_lane

Overview:
- Parametrised successor to the single-lane arrow dropper used in the rhythm game.
- One instance drives one falling note: it waits out a programmable start delay, falls at a programmable speed, and grades the player's key press into PERFECT / GOOD / MISS using a hit window.
- Compared with the fixed-lane dropper, it adds edge-qualified key detection, a two-grade judgement, one-cycle judgement pulses and landing clamping.
- Sits between the keyboard keycode path and the sprite renderer and score tally; sprite bitmaps are out of scope.

Parameters:
- LANE_KEY, 8'h07, keycode that hits this lane.
- START_KEY, 8'h2C, keycode that arms the lane from IDLE.
- RESTART_KEY, 8'h01, keycode that returns HIT/MISS to IDLE.
- CNT_W, 12, width of the delay counter.
- DELAY, 2180, number of WAIT frames before falling; 0 is legal.
- X_START, 160, fixed note X position.
- Y_START, 100, note Y position at IDLE/WAIT.
- SIZE, 40, note height; bottom edge = Y + SIZE.
- Y_MAX, 400, bottom limit; miss line.
- HIT_LO, 340, lowest bottom-edge value inside the hit window.
- PERFECT_CENTER, 370, ideal bottom-edge value.
- PERFECT_TOL, 8, allowed |bottom − PERFECT_CENTER| for a PERFECT grade.
- SPEED, 1, pixels added to Y per FALL frame (1..15).

Ports:
- frame_clk  in  1  frame clock; the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  primary keyboard keycode.
- keycode_second  in  8  secondary keyboard keycode.
- dropX  out  10  note X position.
- dropY  out  10  note Y position (top edge).
- visible  out  1  renderer should draw the note.
- score  out  1  level; 1 while in HIT.
- hit_perfect  out  1  one-frame pulse on a PERFECT hit.
- hit_good  out  1  one-frame pulse on a GOOD hit.
- miss  out  1  one-frame pulse on a miss.

Behaviour:
- Clocking and reset:
  - Single clock domain, rising edge of frame_clk.
  - Reset: clock is frame_clk; reset is asynchronous and active-low, named Reset_n.
  - Reset values: state=IDLE, Y=Y_START, counter=0, key_prev=0, score=0, all pulses=0, visible=0.
- Outputs:
  - dropX is constant X_START.
  - visible=1 in WAIT and FALL only.
- Key detection:
  - pressed = (keycode==LANE_KEY) | (keycode_second==LANE_KEY).
  - key_prev <= pressed every frame in every state.
  - new_press = pressed & ~key_prev.
  - A held key never scores twice and never scores a note that arrives under it.
- Arithmetic: bottom = Y + SIZE, computed 11 bits wide, no overflow.
- IDLE:
  - Holds Y=Y_START, counter=0.
  - keycode==START_KEY → WAIT. Only the primary keycode is checked.
- WAIT:
  - counter increments each frame.
  - When counter == DELAY−1 → FALL.
  - DELAY=0: the first WAIT frame goes straight to FALL.
  - Y is unchanged in WAIT.
- FALL, evaluated each frame in priority order:
  - (1) bottom >= Y_MAX → MISS; miss pulses for 1 frame.
  - (2) new_press & bottom >= HIT_LO → HIT.
    - If |bottom − PERFECT_CENTER| <= PERFECT_TOL, hit_perfect pulses; otherwise hit_good pulses.
    - Y freezes at its current value.
  - (3) Otherwise Y <= Y + SPEED, clamped so bottom never exceeds Y_MAX: if Y+SPEED+SIZE > Y_MAX, Y <= Y_MAX − SIZE.
  - new_press with bottom < HIT_LO is ignored (no penalty).
- Simultaneous events: a press in the same frame that bottom reaches Y_MAX counts as MISS.
- HIT:
  - score=1, Y held.
  - keycode==RESTART_KEY → IDLE, Y=Y_START, counter=0.
- MISS:
  - score=0, Y held at Y_MAX − SIZE.
  - keycode==RESTART_KEY → IDLE.
- Pulse timing: each of hit_perfect / hit_good / miss is registered and asserted exactly in the first frame of the destination state, never more than one per note.
- Mid-operation reset: asserting Reset_n=0 in any state immediately forces the reset values; START_KEY is required again afterwards.
- Illegal state encodings recover to IDLE.

Test Plan:
- Reset/start, DELAY=4:
  - Reset_n low then high → dropY=100, visible=0.
  - keycode=0x2C → WAIT; visible=1.
  - After 4 frames the lane enters FALL and dropY increments by 1 per frame.
- Miss, no key, SPEED=1:
  - Falls 260 frames to dropY=360 (bottom=400).
  - Next frame: miss=1 for one frame, score=0, dropY stays 360.
- Perfect:
  - Press 0x07 on keycode_second when bottom=370 (dropY=330) → hit_perfect=1 one frame, score=1, dropY frozen at 330.
  - keycode=0x01 → IDLE, dropY=100.
- Good vs held key:
  - Press 0x07 first at bottom=345 → hit_good=1.
  - Separate run: 0x07 held from bottom=300 through 400 → no hit, miss pulse fires.
- Clamp and priority, SPEED=7:
  - Bottom sequence 140, 147, …, 399; next step is clamped to dropY=360.
  - Press 0x07 in the frame bottom=400 is evaluated → miss=1, no hit pulse.
- Async reset mid-FALL at dropY=250 → immediate dropY=100, visible=0, score=0; keycode 0x01 alone does not start the lane.
